// File: rtl/mult_err_harness.sv
// Stimulus/checker for the registered approximate multiplier wrapper: issues operand pairs,
// compares returned products with exact ones, accumulates error stats. Option: MULT_ERR_SWEEP_EN.
module mult_err_harness #(
    parameter int          WIDTH       = 16,
    parameter int          LATENCY     = 2,
    parameter int          NUM_SAMPLES = 1024,
    parameter logic [15:0] SEED_X      = 16'hACE1,
    parameter logic [15:0] SEED_Y      = 16'h1D2B
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     x_out,
    output logic [WIDTH-1:0]     y_out,
    input  logic [2*WIDTH-1:0]   p_in,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          sample_cnt,
    output logic [15:0]          mismatch_cnt,
    output logic [2*WIDTH-1:0]   err_max,
    output logic [47:0]          err_sum
);

    localparam int          PW       = 2 * WIDTH;
    localparam logic [15:0] LAST_IDX = 16'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] a, input logic [PW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    state_t               state_r;
    logic [15:0]          issue_cnt_r;
    logic                 out_valid_r;
    logic [LATENCY-1:0]   pipe_valid_r;
    logic [PW-1:0]        pipe_exact_r [LATENCY];
    logic                 start_ok_s;
    logic                 issue_s;
    logic                 pending_s;
    logic [WIDTH-1:0]     gen_x_s;
    logic [WIDTH-1:0]     gen_y_s;
    logic [PW-1:0]        exact_s;
    logic [PW-1:0]        diff_s;
    logic [48:0]          sum_ext_s;

    assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign issue_s    = (state_r == ST_RUN);

`ifdef MULT_ERR_SWEEP_EN
    logic [PW-1:0] sweep_r;

    assign gen_x_s = sweep_r[PW-1:WIDTH];
    assign gen_y_s = sweep_r[WIDTH-1:0];

    // Sweep counter: y is the fast index and carries into x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_r <= {WIDTH'(SEED_X), WIDTH'(SEED_Y)};
        end else if (start_ok_s) begin
            sweep_r <= {WIDTH'(SEED_X), WIDTH'(SEED_Y)};
        end else if (issue_s) begin
            sweep_r <= sweep_r + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            sweep_r <= sweep_r;
        end
    end
`else
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ({1'b0, v[15:1]} ^ LFSR_MASK) : {1'b0, v[15:1]};
    endfunction

    logic [15:0] lfsr_x_r;
    logic [15:0] lfsr_y_r;

    assign gen_x_s = WIDTH'(lfsr_x_r);
    assign gen_y_s = WIDTH'(lfsr_y_r);

    // Galois LFSR pair, reseeded at every accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_x_r <= SEED_X;
            lfsr_y_r <= SEED_Y;
        end else if (start_ok_s) begin
            lfsr_x_r <= SEED_X;
            lfsr_y_r <= SEED_Y;
        end else if (issue_s) begin
            lfsr_x_r <= lfsr_step(lfsr_x_r);
            lfsr_y_r <= lfsr_step(lfsr_y_r);
        end else begin
            lfsr_x_r <= lfsr_x_r;
            lfsr_y_r <= lfsr_y_r;
        end
    end
`endif

    // Operand registers; they keep the last pair through drain and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_out <= '0;
            y_out <= '0;
        end else if (issue_s) begin
            x_out <= gen_x_s;
            y_out <= gen_y_s;
        end else begin
            x_out <= x_out;
            y_out <= y_out;
        end
    end

    // Exact product of the operands currently presented to the wrapper.
    always_comb begin
        exact_s = {{WIDTH{1'b0}}, x_out} * {{WIDTH{1'b0}}, y_out};
    end

    // Expected-product delay line; its last stage lines up with p_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            pipe_valid_r <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_exact_r[i] <= '0;
        end else if (start_ok_s) begin
            out_valid_r  <= 1'b0;
            pipe_valid_r <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_exact_r[i] <= pipe_exact_r[i];
        end else begin
            out_valid_r     <= issue_s;
            pipe_valid_r[0] <= out_valid_r;
            pipe_exact_r[0] <= exact_s;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_exact_r[i] <= pipe_exact_r[i-1];
            end
        end
    end

    // Drain ends when only the final tap (being checked this cycle) can still be valid.
    always_comb begin
        pending_s = out_valid_r;
        for (int i = 0; i < LATENCY - 1; i++) begin
            pending_s = pending_s | pipe_valid_r[i];
        end
    end

    // Control FSM with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            issue_cnt_r <= 16'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r     <= ST_RUN;
                        issue_cnt_r <= 16'd0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RUN: begin
                    issue_cnt_r <= issue_cnt_r + 16'd1;
                    if (issue_cnt_r == LAST_IDX) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (!pending_s) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Error of the aligned sample and its saturating accumulation.
    always_comb begin
        diff_s    = abs_diff(pipe_exact_r[LATENCY-1], p_in);
        sum_ext_s = {1'b0, err_sum} + {{(49-PW){1'b0}}, diff_s};
    end

    // Statistics: cleared on accepted start, updated only by valid taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt   <= 16'd0;
            mismatch_cnt <= 16'd0;
            err_max      <= '0;
            err_sum      <= 48'd0;
        end else if (start_ok_s) begin
            sample_cnt   <= 16'd0;
            mismatch_cnt <= 16'd0;
            err_max      <= '0;
            err_sum      <= 48'd0;
        end else if (pipe_valid_r[LATENCY-1]) begin
            sample_cnt   <= sample_cnt + 16'd1;
            mismatch_cnt <= mismatch_cnt + {15'd0, (diff_s != '0)};
            err_max      <= (diff_s > err_max) ? diff_s : err_max;
            err_sum      <= sum_ext_s[48] ? {48{1'b1}} : sum_ext_s[47:0];
        end else begin
            sample_cnt   <= sample_cnt;
            mismatch_cnt <= mismatch_cnt;
            err_max      <= err_max;
            err_sum      <= err_sum;
        end
    end

endmodule

// File: tb/tb_mult_err_harness.sv
// Directed bench for mult_err_harness: three harness instances against exact, zero and
// exact+1 wrapper models; a sweep-mode instance is added when MULT_ERR_SWEEP_EN is defined.
module tb_mult_err_harness;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, start_bc;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] xa, ya, xb, yb, xc, yc;
    logic [31:0] pa, pc;
    logic [15:0] xa_r, ya_r, xc_r, yc_r;
    logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;
    logic [15:0] scnt_a, mcnt_a, scnt_b, mcnt_b, scnt_c, mcnt_c;
    logic [31:0] emax_a, emax_b, emax_c;
    logic [47:0] esum_a, esum_b, esum_c;

    mult_err_harness #(.NUM_SAMPLES(1024)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .x_out(xa), .y_out(ya), .p_in(pa),
        .busy(busy_a), .done(done_a), .sample_cnt(scnt_a), .mismatch_cnt(mcnt_a),
        .err_max(emax_a), .err_sum(esum_a));

    mult_err_harness #(.NUM_SAMPLES(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_bc), .x_out(xb), .y_out(yb), .p_in(32'd0),
        .busy(busy_b), .done(done_b), .sample_cnt(scnt_b), .mismatch_cnt(mcnt_b),
        .err_max(emax_b), .err_sum(esum_b));

    mult_err_harness #(.NUM_SAMPLES(100)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_bc), .x_out(xc), .y_out(yc), .p_in(pc),
        .busy(busy_c), .done(done_c), .sample_cnt(scnt_c), .mismatch_cnt(mcnt_c),
        .err_max(emax_c), .err_sum(esum_c));

    // Two-register wrapper models: exact for A, exact+1 for C.
    always @(posedge clk) begin
        xa_r <= xa;
        ya_r <= ya;
        pa   <= {16'd0, xa_r} * {16'd0, ya_r};
        xc_r <= xc;
        yc_r <= yc;
        pc   <= ({16'd0, xc_r} * {16'd0, yc_r}) + 32'd1;
    end

`ifdef MULT_ERR_SWEEP_EN
    logic        start_d, busy_d, done_d;
    logic [15:0] xd, yd, scnt_d, mcnt_d;
    logic [31:0] emax_d;
    logic [47:0] esum_d;

    mult_err_harness #(.NUM_SAMPLES(3), .SEED_X(16'h0000), .SEED_Y(16'hFFFE)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start_d), .x_out(xd), .y_out(yd), .p_in(32'd0),
        .busy(busy_d), .done(done_d), .sample_cnt(scnt_d), .mismatch_cnt(mcnt_d),
        .err_max(emax_d), .err_sum(esum_d));
`endif

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_a(input int extra_at, output int cyc);
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        cyc = 0;
        while (done_a !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start_a = (cyc == extra_at);
        end
        start_a = 1'b0;
    endtask

    int cyc, cyc_b, cyc_c;

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_bc = 1'b0;
`ifdef MULT_ERR_SWEEP_EN
        start_d = 1'b0;
`endif
        #1;
        check_val("rst_busy", {63'd0, busy_a}, 64'd0);
        check_val("rst_done", {63'd0, done_a}, 64'd0);
        check_val("rst_x", {48'd0, xa}, 64'd0);
        check_val("rst_sum", {16'd0, esum_a}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Exact model: clean statistics and run length NUM_SAMPLES+3.
        run_a(-1, cyc);
        check_val("a_cycles", 64'(cyc), 64'd1027);
        check_val("a_samples", {48'd0, scnt_a}, 64'd1024);
        check_val("a_mismatch", {48'd0, mcnt_a}, 64'd0);
        check_val("a_errmax", {32'd0, emax_a}, 64'd0);
        check_val("a_errsum", {16'd0, esum_a}, 64'd0);
        check_val("a_busy_done", {63'd0, busy_a}, 64'd0);

        // Restart while busy is ignored.
        run_a(10, cyc);
        check_val("a2_cycles", 64'(cyc), 64'd1027);
        check_val("a2_samples", {48'd0, scnt_a}, 64'd1024);
        check_val("a2_mismatch", {48'd0, mcnt_a}, 64'd0);

        // B: p_in tied to zero, one sample. C: exact+1 model, 100 samples.
        @(negedge clk) start_bc = 1'b1;
        @(negedge clk) start_bc = 1'b0;
        cyc = 0; cyc_b = -1; cyc_c = -1;
        while ((done_b !== 1'b1 || done_c !== 1'b1) && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (done_b === 1'b1 && cyc_b < 0) cyc_b = cyc;
            if (done_c === 1'b1 && cyc_c < 0) cyc_c = cyc;
        end
        check_val("b_cycles", 64'(cyc_b), 64'd4);
        check_val("b_x", {48'd0, xb}, 64'h0000_0000_0000_ACE1);
        check_val("b_samples", {48'd0, scnt_b}, 64'd1);
        check_val("b_mismatch", {48'd0, mcnt_b}, 64'd1);
        check_val("b_errmax", {32'd0, emax_b}, 64'h0000_0000_13B2_86CB);
        check_val("b_errsum", {16'd0, esum_b}, 64'h0000_0000_13B2_86CB);
        check_val("c_cycles", 64'(cyc_c), 64'd103);
        check_val("c_samples", {48'd0, scnt_c}, 64'd100);
        check_val("c_mismatch", {48'd0, mcnt_c}, 64'd100);
        check_val("c_errmax", {32'd0, emax_c}, 64'd1);
        check_val("c_errsum", {16'd0, esum_c}, 64'd100);

        // Mid-run reset aborts; the next run replays the seeded sequence.
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (50) @(negedge clk);
        check_val("mid_busy", {63'd0, busy_a}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", {63'd0, busy_a}, 64'd0);
        check_val("abort_done", {63'd0, done_a}, 64'd0);
        check_val("abort_samples", {48'd0, scnt_a}, 64'd0);
        check_val("abort_x", {48'd0, xa}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        @(negedge clk);
        check_val("seq0_x", {48'd0, xa}, 64'h0000_0000_0000_ACE1);
        check_val("seq0_y", {48'd0, ya}, 64'h0000_0000_0000_1D2B);
        @(negedge clk);
        check_val("seq1_x", {48'd0, xa}, 64'h0000_0000_0000_E270);
        check_val("seq1_y", {48'd0, ya}, 64'h0000_0000_0000_BA95);
        @(negedge clk);
        check_val("seq2_x", {48'd0, xa}, 64'h0000_0000_0000_7138);
        check_val("seq2_y", {48'd0, ya}, 64'h0000_0000_0000_E94A);

`ifdef MULT_ERR_SWEEP_EN
        @(negedge clk) start_d = 1'b1;
        @(negedge clk) start_d = 1'b0;
        @(negedge clk);
        check_val("sw0", {32'd0, xd, yd}, 64'h0000_0000_0000_FFFE);
        @(negedge clk);
        check_val("sw1", {32'd0, xd, yd}, 64'h0000_0000_0000_FFFF);
        @(negedge clk);
        check_val("sw2", {32'd0, xd, yd}, 64'h0000_0000_0001_0000);
        repeat (4) @(negedge clk);
        check_val("sw_done", {63'd0, done_d}, 64'd1);
        check_val("sw_hold", {32'd0, xd, yd}, 64'h0000_0000_0001_0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_err_harness.md
Name: mult_err_harness

Overview:
On-chip stimulus and checker for the registered 16x16 approximate multiplier wrapper, sitting on the opposite side of that wrapper's x/y/p_out interface.
- Drives pseudo-random operand pairs onto x/y every cycle and captures the product LATENCY cycles later.
- Compares each captured product against an internally computed exact product and accumulates error statistics (sum, max, mismatch count) for silicon and FPGA characterisation of the approximate multipliers.

Parameters:
WIDTH, 16, operand width; product width is 2*WIDTH
LATENCY, 2, cycles from an operand appearing on x_out to the matching product on p_in (wrapper input reg + output reg)
NUM_SAMPLES, 1024, operand pairs issued per run; legal range 1..65535
SEED_X, 16'hACE1, x LFSR seed; must be nonzero
SEED_Y, 16'h1D2B, y LFSR seed; must be nonzero

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run when idle
x_out  out  WIDTH  operand X to multiplier wrapper
y_out  out  WIDTH  operand Y to multiplier wrapper
p_in  in  2*WIDTH  registered product from multiplier wrapper
busy  out  1  high from accepted start until done asserts
done  out  1  high in DONE state; held until next accepted start
sample_cnt  out  16  products checked so far this run
mismatch_cnt  out  16  products with p_in != exact
err_max  out  2*WIDTH  largest |exact - p_in| this run
err_sum  out  48  sum of |exact - p_in|; saturates at all-ones

Behaviour:
- Interface decision: one clock `clk`; reset `rst_n`, asynchronous assert, active low. On reset, all outputs are 0, FSM = IDLE, and LFSRs reload their seeds.
- FSM states are IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 moves to RUN.
  - Clears all statistics and issue/valid state.
  - Reloads LFSRs with SEED_X and SEED_Y.
  - busy=1 from the next cycle.
- DONE: start=1 behaves as in IDLE (clears done and starts a new run).
- start while busy is ignored.
- RUN: each cycle, x_out/y_out take the current LFSR values, then both LFSRs advance.
  - LFSRs are 16-bit Galois, mask 16'hB400 (x^16+x^14+x^13+x^11+1).
  - After NUM_SAMPLES pairs have been issued, move to DRAIN.
  - x_out/y_out hold their last value through DRAIN.
- Expected-product pipeline: a LATENCY-deep shift register of {valid, exact = x_out*y_out} (unsigned, 2*WIDTH bits), loaded in step with x_out/y_out.
  - The valid tap aligns the exact value with p_in.
  - Valid=0 entries (pipeline fill, DRAIN bubbles) never update statistics.
- Check, on each cycle the tap is valid:
  - diff = exact >= p_in ? exact - p_in : p_in - exact
  - sample_cnt += 1
  - mismatch_cnt += (diff != 0)
  - err_max = max(err_max, diff)
  - err_sum += diff, saturating to 48'hFFFF_FFFF_FFFF
- DRAIN: lasts until the pipeline holds no valid entry, which takes exactly LATENCY cycles. Then go to DONE: busy=0, done=1.
- Total run length, start to done: NUM_SAMPLES + LATENCY + 1 cycles.
- At done, sample_cnt == NUM_SAMPLES exactly.
- Statistics hold their values in DONE until the next accepted start.
- rst_n low mid-run aborts immediately: all state is cleared and the FSM returns to IDLE with no partial done.
- Counters never wrap, because NUM_SAMPLES ≤ 65535 bounds them.

Optional Feature:
MULT_ERR_SWEEP_EN
- Defined: the LFSRs are replaced by a 2*WIDTH-bit sweep counter {x_out, y_out}.
  - Counter starts at {SEED_X, SEED_Y} and increments by 1 per issued pair, so y is the fast index and wraps into x.
  - Used for exhaustive corner coverage near the seed.
  - Everything else is unchanged.
- Undefined: LFSR operand generation as specified above. No sweep counter logic is present.

Test Plan:
1. Exact-multiplier model wired as LATENCY=2 DUT, NUM_SAMPLES=1024, start pulse -> done after 1027 cycles; sample_cnt=1024, mismatch_cnt=0, err_max=0, err_sum=0.
2. p_in tied to 0, NUM_SAMPLES=1 -> sample_cnt=1, err_max=err_sum=16'hACE1*16'h1D2B; mismatch_cnt=1 unless product is 0.
3. DUT model returns exact+1 for every pair, NUM_SAMPLES=100 -> mismatch_cnt=100, err_max=1, err_sum=100.
4. start pulsed again at cycle 10 of a run -> ignored; done timing and counts identical to a single-start run.
5. rst_n pulsed low at cycle 50 of a run -> all outputs 0 and busy=0 immediately. A following start reproduces the exact operand sequence beginning 16'hACE1/16'h1D2B.
6. With MULT_ERR_SWEEP_EN, SEED_X=0, SEED_Y=16'hFFFE, NUM_SAMPLES=3 -> x_out/y_out sequence is (0,FFFE), (0,FFFF), (1,0000).
